fwd_hazard_scoreboard: RTL
==========================

# fwd_hazard_scoreboard

Parametrised forwarding and load-use interlock unit for the pipelined core, sitting between the RR/EX pipeline register and the EX operand muxes. It keeps a registered shift-register record of every in-flight register writer for DEPTH stages past EX and generates a forwarding select per source operand. Youngest-match priority applies. When a source depends on a load still in its first tracked stage, it requests a one-cycle stall and injects a bubble into its own tracking.

## Interface
- REG_AW, default 3: register address width.
- DEPTH, default 3: number of tracked producer stages past EX. Stage 0 is EX/MEM, stage 1 is MEM/WB, stage 2 is the post-WB instruction.
- NUM_SRC, default 2: number of source operands checked in parallel.
- SEL_W, default 2: forwarding select width. It must satisfy 2^SEL_W >= DEPTH+1; an elaboration check enforces this.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  the RR/EX instruction is real (not a bubble).
- iss_wr_en  in  1  the issuing instruction writes a register.
- iss_rd  in  REG_AW  destination of the issuing instruction.
- iss_is_load  in  1  the issuing instruction is a load; its data is available from stage 1 onward.
- src_addr  in  NUM_SRC*REG_AW  packed source addresses; operand i occupies bits [i*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  operand i is actually read by the instruction.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  kill the issuing instruction (branch mispredict).
- fwd_sel  out  NUM_SRC*SEL_W  select for operand i. 0 means register-file data; k+1 means forward from stage k.
- load_stall  out  1  request to hold the front end and bubble EX.
- stall_cnt  out  16  load-use stall counter; present only with the macro defined (see Configuration).

## Operation
- Each stage k holds the entry {v, rd, ld}. Reset clears every v, rd and ld to 0.
- Match for operand i at stage k: src_used[i] && v[k] && rd[k] == src_addr[i].
- fwd_sel[i] = k+1 for the lowest matching k, else 0. The youngest producer wins when several stages hold the same rd.
- load_stall = iss_valid && !flush && (any i matches stage 0 with ld[0] = 1). A match with ld[0] = 1 at stage 0 never selects stage 0. That operand's fwd_sel is 0 for the cycle, and the value is a don't-care because the instruction is stalled.
- Update rules, in priority order:
  - reset: all entries are cleared.
  - hold: all entries keep their values.
  - load_stall or flush: entry k moves to k+1, and stage 0 gets a bubble (v = 0).
  - otherwise: entry k moves to k+1, and stage 0 gets {iss_valid && iss_wr_en, iss_rd, iss_is_load}.
- The entry in stage DEPTH-1 is discarded on every shift.
- flush and load_stall together: the flush rule applies, a bubble is inserted, and stall_cnt is not incremented.

## Timing
- fwd_sel and load_stall are combinational from registered entries plus the current src_addr, src_used, iss_valid and flush. There are no combinational paths from iss_rd, iss_wr_en or iss_is_load.
- Writer issued in cycle t (no hold): it occupies stage 0 at t+1, stage 1 at t+2, and so on. A dependent in cycle t+1+k sees fwd_sel = k+1.
- Load-use: the dependent in cycle t+1 gets load_stall = 1 for exactly one cycle. In cycle t+2 the load is in stage 1, so fwd_sel = 2 and load_stall = 0.
- hold freezes entries, so the outputs stay stable while the inputs are stable.
- Reset asserted mid-stream takes effect on the next edge. All outputs are 0 in the cycle after reset.

## Configuration
- FWD_STALL_CNT_EN defined: the stall_cnt port and a 16-bit saturating counter exist. The counter resets to 0 and increments on each edge where load_stall && !hold && !flush. It saturates at 16'hFFFF.
- FWD_STALL_CNT_EN undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Back-to-back ALU dependency: issue a writer to R3, next cycle src_addr[0] = 3 -> fwd_sel[0] = 1, load_stall = 0. Repeat with gaps of 1 and 2 idle cycles -> fwd_sel[0] = 2 and 3. A gap of 3 -> fwd_sel[0] = 0.
- Youngest wins: writers to R5 in cycles t and t+1, dependent on R5 in t+2 -> fwd_sel = 1, not 2.
- Load-use: load to R2, next cycle src_addr[1] = 2 -> load_stall = 1 for one cycle. The following cycle gives fwd_sel[1] = 2 and load_stall = 0. With the macro, stall_cnt goes 0 -> 1.
- Unused and non-writing operands: src_used[0] = 0 with a matching address -> fwd_sel[0] = 0. A writer issued with iss_wr_en = 0 produces no later match.
- Hold and flush: hold for 4 cycles with a writer in stage 0 -> fwd_sel stays 1 throughout. Flush in the writer's issue cycle -> no later match. Flush plus a load-use match -> bubble inserted, stall_cnt unchanged.
- Reset mid-stream: entries valid in all stages, pulse reset -> next cycle all fwd_sel = 0, load_stall = 0, stall_cnt = 0.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and load-use interlock for the EX operand muxes.
// Latency: fwd_sel/load_stall are combinational from the tracked entries; entries advance one stage per unheld edge.
// Backpressure: hold freezes tracking; load_stall asks the front end to hold and bubbles EX into the tracker.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_iss_*                issuing instruction (valid, writes, destination, load)
//   i_src_addr, i_src_used packed source operand addresses and use flags
//   i_hold, i_flush        pipeline freeze, kill of the issuing instruction
//   o_fwd_sel              per-operand select: 0 = register file, k+1 = stage k
//   o_load_stall           load-use interlock request
//   o_stall_cnt            saturating load-use stall counter (only with FWD_STALL_CNT_EN)
//
// Optional feature macro: FWD_STALL_CNT_EN adds o_stall_cnt and its counter.
module fwd_hazard_scoreboard #(
  parameter int REG_AW  = 3,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_iss_valid,
  input  logic                      i_iss_wr_en,
  input  logic [REG_AW-1:0]         i_iss_rd,
  input  logic                      i_iss_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] i_src_addr,
  input  logic [NUM_SRC-1:0]        i_src_used,
  input  logic                      i_hold,
  input  logic                      i_flush,
  output logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel,
  output logic                      o_load_stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]               o_stall_cnt
`endif
);

  if ((1 << SEL_W) < DEPTH + 1) begin : g_bad_sel_w
    $error("fwd_hazard_scoreboard: SEL_W too narrow to encode DEPTH+1 selects");
  end

  // Tracked producers. The load flag only matters while the producer sits in
  // stage 0 (from stage 1 on its data is forwardable), so only stage 0 keeps it.
  logic [DEPTH-1:0] r_v;
  logic [REG_AW-1:0] r_rd [DEPTH];
  logic              r_ld0;

  logic [NUM_SRC-1:0] w_ld_hit;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [SEL_W-1:0]  w_sel;
    logic              w_hit_ld;
    logic [REG_AW-1:0] w_addr;

    assign w_addr = i_src_addr[gi*REG_AW +: REG_AW];

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
      w_sel    = '0;
      w_hit_ld = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (i_src_used[gi] && r_v[k] && (r_rd[k] == w_addr)) begin
          w_sel    = SEL_W'(k + 1);
          w_hit_ld = (k == 0) && r_ld0;
        end
      end
      // Load data is not ready in stage 0; the operand is stalled, not forwarded.
      if (w_hit_ld) w_sel = '0;
    end

    assign o_fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
    assign w_ld_hit[gi]                 = w_hit_ld;
  end

  assign o_load_stall = i_iss_valid && !i_flush && (|w_ld_hit);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v   <= '0;
      r_ld0 <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_rd[k] <= '0;
    end else if (!i_hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_v[k]  <= r_v[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      if (o_load_stall || i_flush) begin
        r_v[0]  <= 1'b0;
        r_rd[0] <= '0;
        r_ld0   <= 1'b0;
      end else begin
        r_v[0]  <= i_iss_valid && i_iss_wr_en;
        r_rd[0] <= i_iss_rd;
        r_ld0   <= i_iss_is_load;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (o_load_stall && !i_hold && !i_flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
